// File: rtl/mux_canais_reg.sv
// Registered N-channel multiplexer with optional round-robin scan (MUX_CANAIS_VARREDURA_EN).
// Latency: 1 cycle from the capture edge to resultado/canal/valido/erro.
// Backpressure: a held word stays stable until pronto; consume and capture may share a cycle.
module mux_canais_reg #(
   parameter int LARGURA = 8,
   parameter int CANAIS  = 4,
   localparam int SEL    = $clog2(CANAIS)
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [CANAIS*LARGURA-1:0]  entradas,
   input  logic [SEL-1:0]             controle,
   input  logic                       carregar,
   input  logic                       modo,
   input  logic                       pronto,
   output logic [LARGURA-1:0]         resultado,
   output logic [SEL-1:0]             canal,
   output logic                       valido,
   output logic                       erro
);

   // Channel count widened by one bit so an index equal to CANAIS compares correctly.
   localparam logic [SEL:0] NCANAIS = (SEL+1)'(CANAIS);

   logic               livre;
   logic               varre;
   logic               captura;
   logic [SEL-1:0]     idx;
   logic               fora;
   logic [LARGURA-1:0] sel_dat;

   // Slot accepts a new word when empty or when the held word leaves this cycle.
   assign livre = !valido || pronto;

`ifdef MUX_CANAIS_VARREDURA_EN
   logic [SEL-1:0] ptr;
   localparam logic [SEL-1:0] PTR_MAX = SEL'(CANAIS-1);

   assign varre = modo;
   assign idx   = varre ? ptr : controle;

   // Scan pointer moves only on scan captures and wraps at the last channel.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (captura && varre) begin
         ptr <= (ptr == PTR_MAX) ? '0 : ptr + SEL'(1);
      end
   end
`else
   // Without scan support the mode input is forced to direct.
   assign varre = modo & 1'b0;
   assign idx   = controle;
`endif

   // Scan captures on every free cycle; direct mode needs the load strobe.
   assign captura = livre && (varre || carregar);

   // Out-of-range index can only come from controle; ptr never leaves the channel range.
   assign fora = ({1'b0, idx} >= NCANAIS);

   // Select the indexed channel; an out-of-range index yields zero.
   always_comb begin
      sel_dat = '0;
      for (int k = 0; k < CANAIS; k++) begin
         if (idx == SEL'(k)) begin
            sel_dat = entradas[k*LARGURA +: LARGURA];
         end
      end
   end

   // Output register: capture, drain on consume, otherwise hold.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         resultado <= '0;
         canal     <= '0;
         valido    <= 1'b0;
         erro      <= 1'b0;
      end else if (captura) begin
         resultado <= sel_dat;
         canal     <= idx;
         valido    <= 1'b1;
         erro      <= fora;
      end else if (pronto) begin
         valido    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_canais_reg.sv
module tb_mux_canais_reg;

   logic        clock;
   logic        reset_n;

   // CANAIS=4 instance
   logic [31:0] entradas;
   logic [1:0]  controle;
   logic        carregar;
   logic        modo;
   logic        pronto;
   logic [7:0]  resultado;
   logic [1:0]  canal;
   logic        valido;
   logic        erro;

   // CANAIS=3 instance
   logic [23:0] entradas3;
   logic [1:0]  controle3;
   logic        carregar3;
   logic        modo3;
   logic        pronto3;
   logic [7:0]  resultado3;
   logic [1:0]  canal3;
   logic        valido3;
   logic        erro3;

   int vectors;
   int miscompares;

   mux_canais_reg #(.LARGURA(8), .CANAIS(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .entradas(entradas), .controle(controle),
      .carregar(carregar), .modo(modo), .pronto(pronto), .resultado(resultado),
      .canal(canal), .valido(valido), .erro(erro)
   );

   mux_canais_reg #(.LARGURA(8), .CANAIS(3)) dut3 (
      .clock(clock), .reset_n(reset_n), .entradas(entradas3), .controle(controle3),
      .carregar(carregar3), .modo(modo3), .pronto(pronto3), .resultado(resultado3),
      .canal(canal3), .valido(valido3), .erro(erro3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk4(input string tag, input logic [7:0] r, input logic [1:0] c,
                       input logic v, input logic e);
      chk({tag, ".resultado"}, 32'(resultado), 32'(r));
      chk({tag, ".canal"},     32'(canal),     32'(c));
      chk({tag, ".valido"},    32'(valido),    32'(v));
      chk({tag, ".erro"},      32'(erro),      32'(e));
   endtask

   task automatic chk3(input string tag, input logic [7:0] r, input logic [1:0] c,
                       input logic v, input logic e);
      chk({tag, ".resultado"}, 32'(resultado3), 32'(r));
      chk({tag, ".canal"},     32'(canal3),     32'(c));
      chk({tag, ".valido"},    32'(valido3),    32'(v));
      chk({tag, ".erro"},      32'(erro3),      32'(e));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n   = 1'b0;
      entradas  = 32'h44332211;
      controle  = 2'd0;
      carregar  = 1'b0;
      modo      = 1'b0;
      pronto    = 1'b0;
      entradas3 = 24'h332211;
      controle3 = 2'd0;
      carregar3 = 1'b0;
      modo3     = 1'b0;
      pronto3   = 1'b0;

      // Held in reset across edges
      tick();
      tick();
      chk4("reset_hold", 8'h00, 2'd0, 1'b0, 1'b0);
      chk3("reset_hold3", 8'h00, 2'd0, 1'b0, 1'b0);
      reset_n = 1'b1;

      // Direct capture on the first edge after reset release
      carregar = 1'b1; controle = 2'd2; pronto = 1'b0;
      tick();
      chk4("direct_c2", 8'h33, 2'd2, 1'b1, 1'b0);

      // Slot full: new select ignored for three cycles
      controle = 2'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk4("hold_full", 8'h33, 2'd2, 1'b1, 1'b0);
      end

      // Consume and capture in the same cycle
      pronto = 1'b1; controle = 2'd3;
      tick();
      chk4("b2b_c3", 8'h44, 2'd3, 1'b1, 1'b0);

      // Consume without capture: valido drops, data kept
      carregar = 1'b0;
      tick();
      chk4("drain", 8'h44, 2'd3, 1'b0, 1'b0);

      // Pronto while empty has no effect
      tick();
      chk4("pronto_empty", 8'h44, 2'd3, 1'b0, 1'b0);

      // Entradas changes after capture do not affect the held word
      carregar = 1'b1; controle = 2'd0; pronto = 1'b0;
      tick();
      chk4("direct_c0", 8'h11, 2'd0, 1'b1, 1'b0);
      carregar = 1'b0;
      entradas = 32'h443322A5;
      tick();
      chk4("input_change", 8'h11, 2'd0, 1'b1, 1'b0);
      entradas = 32'h44332211;

      // Asynchronous reset mid-transfer, checked before any clock edge
      #2 reset_n = 1'b0;
      #1;
      chk4("async_reset", 8'h00, 2'd0, 1'b0, 1'b0);
      #1 reset_n = 1'b1;

`ifdef MUX_CANAIS_VARREDURA_EN
      // Scan wrap with pronto high
      modo = 1'b1; pronto = 1'b1; carregar = 1'b0;
      begin
         logic [7:0] sdat [6];
         logic [1:0] scan [6];
         sdat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
         scan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
         for (int i = 0; i < 6; i++) begin
            tick();
            chk4("scan_seq", sdat[i], scan[i], 1'b1, 1'b0);
         end
      end
      // Backpressure holds the word
      pronto = 1'b0;
      tick();
      chk4("scan_hold", 8'h22, 2'd1, 1'b1, 1'b0);
      tick();
      chk4("scan_hold2", 8'h22, 2'd1, 1'b1, 1'b0);
      pronto = 1'b1;
      tick();
      chk4("scan_resume", 8'h33, 2'd2, 1'b1, 1'b0);
      // Direct capture in between leaves the scan pointer alone
      modo = 1'b0; carregar = 1'b1; controle = 2'd1;
      tick();
      chk4("direct_mid", 8'h22, 2'd1, 1'b1, 1'b0);
      modo = 1'b1; carregar = 1'b0;
      tick();
      chk4("scan_after_direct", 8'h44, 2'd3, 1'b1, 1'b0);
      modo = 1'b0;
      tick();
      chk4("scan_drain", 8'h44, 2'd3, 1'b0, 1'b0);
`else
      // Scan not built: modo is ignored
      modo = 1'b1; pronto = 1'b1; carregar = 1'b0;
      tick();
      chk4("modo_ignored", 8'h00, 2'd0, 1'b0, 1'b0);
      carregar = 1'b1; controle = 2'd1;
      tick();
      chk4("modo_direct", 8'h22, 2'd1, 1'b1, 1'b0);
      carregar = 1'b0; modo = 1'b0;
      tick();
      chk4("modo_drain", 8'h22, 2'd1, 1'b0, 1'b0);
`endif

      // Out-of-range select on the 3-channel instance
      carregar3 = 1'b1; controle3 = 2'd3; pronto3 = 1'b0;
      tick();
      chk3("oor", 8'h00, 2'd3, 1'b1, 1'b1);
      pronto3 = 1'b1; controle3 = 2'd0;
      tick();
      chk3("oor_clear", 8'h11, 2'd0, 1'b1, 1'b0);
      controle3 = 2'd2;
      tick();
      chk3("c3_last", 8'h33, 2'd2, 1'b1, 1'b0);
      carregar3 = 1'b0;
      tick();
      chk3("c3_drain", 8'h33, 2'd2, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mux_canais_reg.md
# mux_canais_reg

Parametrised, registered N-channel multiplexer for the 8-bit processor datapath, the successor to the fixed 2-input combinational MUX. It selects one of CANAIS input words of LARGURA bits and presents it on a registered output with a valid/ready handshake. An optional scan mode walks all channels in round-robin order. It sits between register-file or peripheral read ports and the consumers that need a held, flow-controlled word.

## Interface
Parameters:
- LARGURA, 8: width of each channel word in bits.
- CANAIS, 4: number of input channels, ≥2; need not be a power of two.
- SEL: derived localparam, equal to $clog2(CANAIS); width of channel indices.

Ports:
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Entradas  in  CANAIS*LARGURA  packed inputs; channel k is Entradas[k*LARGURA +: LARGURA].
- Controle  in  SEL  channel index used in direct mode.
- Carregar  in  1  capture strobe for direct mode.
- Modo  in  1  0 = direct, 1 = scan (scan only if compiled in).
- Pronto  in  1  consumer accepts the current output word.
- Resultado  out  LARGURA  registered selected word.
- Canal  out  SEL  index of the channel held in Resultado.
- Valido  out  1  Resultado/Canal hold an unconsumed word.
- Erro  out  1  the last capture used an out-of-range Controle.

## Operation
- Output slot is free when Valido==0, or when Valido==1 and Pronto==1 (consume and capture in the same cycle).
- Direct mode (Modo=0): on a free cycle with Carregar=1, capture Entradas[Controle] into Resultado and Controle into Canal. Set Valido=1. Set Erro=0.
- Direct mode, out-of-range Controle (Controle ≥ CANAIS): capture Resultado=0 and Canal=Controle. Set Valido=1 and Erro=1.
- Scan mode (Modo=1): on every free cycle, capture Entradas[ptr] and set Canal=ptr, Valido=1, Erro=0. ptr then advances by 1 and wraps from CANAIS-1 to 0. Carregar and Controle are ignored.
- ptr is internal, resets to 0, and advances only on scan captures. Direct captures leave it unchanged.
- A slot that is not free holds Resultado, Canal, Valido and Erro stable whatever Carregar, Modo or Entradas do.
- Valido==1 and Pronto==1 with no new capture (direct mode, Carregar=0): Valido clears to 0 next edge; Resultado and Canal keep their last values.
- Pronto while Valido==0 has no effect.
- A Modo change takes effect at the next free cycle. No word is dropped or duplicated.

## Timing
- Reset (Reset_n low, asynchronous): Resultado=0, Canal=0, Valido=0, Erro=0, ptr=0. Takes effect immediately, mid-transfer included. A held word is discarded.
- The first edge after Reset_n deasserts can capture.
- Latency: 1 cycle. Inputs sampled at edge t appear on the outputs after edge t.
- Throughput: 1 word per cycle when Pronto is held high.
- Entradas is sampled only at the capture edge. Later changes do not affect a held word.

## Configuration
- MUX_CANAIS_VARREDURA_EN defined: scan mode and the ptr register are present, as described above.
- MUX_CANAIS_VARREDURA_EN undefined: Modo is ignored and always treated as 0. ptr logic is not synthesised. All other behaviour is unchanged.

## Test plan
Defaults are LARGURA=8, CANAIS=4, with Entradas channels = 8'h11, 8'h22, 8'h33, 8'h44.
- Reset check: pulse Reset_n low between edges -> Resultado=0, Canal=0, Valido=0, Erro=0 immediately, without waiting for a clock edge.
- Direct capture: Modo=0, Carregar=1, Controle=2, Pronto=0 -> next cycle Resultado=8'h33, Canal=2, Valido=1. Then set Controle=1 with Carregar held and Pronto=0 -> outputs stay at 8'h33 for 3 cycles.
- Back-to-back transfer: Valido=1, Pronto=1, Carregar=1, Controle=3 -> next cycle Resultado=8'h44, Valido=1. Then Pronto=1, Carregar=0 -> Valido=0 and Resultado stays 8'h44.
- Scan wrap: Modo=1, Pronto=1 for 6 cycles -> Canal sequence 0,1,2,3,0,1 and Resultado sequence 11,22,33,44,11,22. Drop Pronto mid-sequence -> the word holds and the sequence resumes with no channel skipped.
- Out-of-range select: CANAIS=3, Modo=0, Carregar=1, Controle=3 -> Resultado=0, Canal=3, Erro=1, Valido=1. Next valid capture with Controle=0 -> Erro=0.
- Macro off: MUX_CANAIS_VARREDURA_EN undefined, Modo=1, Carregar=0 -> no capture and Valido stays 0. With Carregar=1 and Controle=1 -> Resultado=8'h22.
